// File: rtl/param_step_counter_pkg.sv
// Shared constants and types for the step counter and every block that drives it.
package param_step_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } inc_op_e;

endpackage

// File: rtl/param_incrementer.sv
// Combinational WIDTH-bit add/subtract of an operand, with carry-out on add
// and borrow-out on subtract.
module param_incrementer
  import param_step_counter_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  inc_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flow_o
);

  logic [WIDTH:0] ext;

  // The extra MSB holds the carry for add, and the borrow (b > a) for subtract.
  always_comb begin
    if (op_i == OP_SUB) ext = {1'b0, a_i} - {1'b0, b_i};
    else                ext = {1'b0, a_i} + {1'b0, b_i};
  end

  assign result_o = ext[WIDTH-1:0];
  assign flow_o   = ext[WIDTH];

endmodule

// File: rtl/param_step_counter.sv
// Registered up/down step counter with load, clear, wrap/saturate modes,
// a one-cycle carry pulse and a sticky overflow flag.
module param_step_counter
  import param_step_counter_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               STEP_W      = 4,
  parameter int               SATURATE    = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              count_en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  count,
  output logic              carry,
  output logic              ovf_sticky,
  output logic              at_max,
  output logic              at_min
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] inc_result;
  logic             inc_flow;
  inc_op_e          inc_op;

  assign step_ext = WIDTH'(step);
  assign inc_op   = (dir == DIR_DOWN) ? OP_SUB : OP_ADD;

  param_incrementer #(
    .WIDTH(WIDTH)
  ) u_inc (
    .a_i     (count_q),
    .b_i     (step_ext),
    .op_i    (inc_op),
    .result_o(inc_result),
    .flow_o  (inc_flow)
  );

  // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (clr) begin
      count_d = RESET_VALUE;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_value;
    end else if (count_en) begin
      count_d = inc_result;
      if (inc_flow) begin
        carry_d = 1'b1;
        ovf_d   = 1'b1;  // a new overflow beats a coincident ovf_clr
        if (SATURATE != 0) count_d = (dir == DIR_DOWN) ? '0 : '1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so all state updates together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VALUE;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign carry      = carry_q;
  assign ovf_sticky = ovf_q;
  assign at_max     = &count_q;
  assign at_min     = ~|count_q;

endmodule

// File: tb/tb_param_step_counter.sv
// Scoreboard bench driving a wrapping and a saturating counter with the same
// stimulus and comparing both against an independent reference model.
module tb_param_step_counter;
  import param_step_counter_pkg::*;

  localparam int W  = 10;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0, load = 1'b0, count_en = 1'b0, dir = DIR_UP, ovf_clr = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [SW-1:0] step = '0;

  logic [W-1:0]  w_count, s_count;
  logic          w_carry, s_carry, w_ovf, s_ovf, w_max, s_max, w_min, s_min;

  param_step_counter #(.WIDTH(W), .STEP_W(SW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_value(load_value),
    .count_en(count_en), .dir(dir), .step(step), .ovf_clr(ovf_clr),
    .count(w_count), .carry(w_carry), .ovf_sticky(w_ovf), .at_max(w_max), .at_min(w_min)
  );

  param_step_counter #(.WIDTH(W), .STEP_W(SW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_value(load_value),
    .count_en(count_en), .dir(dir), .step(step), .ovf_clr(ovf_clr),
    .count(s_count), .carry(s_carry), .ovf_sticky(s_ovf), .at_max(s_max), .at_min(s_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] count;
    logic         carry;
    logic         ovf;
  } st_t;

  typedef struct {
    string tag;
    st_t   w;
    st_t   s;
  } exp_t;

  exp_t sb[$];
  st_t  mw, ms;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic st_t model(st_t s, bit sat, bit c, bit ld, logic [W-1:0] lv,
                                bit en, bit d, logic [SW-1:0] st, bit oc);
    st_t n;
    int  v;
    n       = s;
    n.carry = 1'b0;
    if (oc) n.ovf = 1'b0;
    if (c) begin
      n.count = '0;
      n.ovf   = 1'b0;
    end else if (ld) begin
      n.count = lv;
    end else if (en) begin
      if (d == DIR_UP) begin
        v = int'(s.count) + int'(st);
        if (v > (1 << W) - 1) begin
          n.carry = 1'b1;
          n.ovf   = 1'b1;
          v = sat ? (1 << W) - 1 : v - (1 << W);
        end
      end else begin
        v = int'(s.count) - int'(st);
        if (v < 0) begin
          n.carry = 1'b1;
          n.ovf   = 1'b1;
          v = sat ? 0 : v + (1 << W);
        end
      end
      n.count = W'(v);
    end
    return n;
  endfunction

  task automatic compare_one(input string tag, input st_t e, input logic [W-1:0] c,
                             input logic cy, input logic o, input logic mx, input logic mn);
    check({tag, ".count"}, 32'(c), 32'(e.count));
    check({tag, ".carry"}, 32'(cy), 32'(e.carry));
    check({tag, ".ovf"}, 32'(o), 32'(e.ovf));
    check({tag, ".at_max"}, 32'(mx), 32'(e.count == '1));
    check({tag, ".at_min"}, 32'(mn), 32'(e.count == '0));
  endtask

  // Drive one cycle of stimulus, push the model's expectation, then check after the edge.
  task automatic cyc(input string tag, input bit c, input bit ld, input logic [W-1:0] lv,
                     input bit en, input bit d, input logic [SW-1:0] st, input bit oc);
    exp_t e;
    clr = c; load = ld; load_value = lv; count_en = en; dir = d; step = st; ovf_clr = oc;
    mw = model(mw, 1'b0, c, ld, lv, en, d, st, oc);
    ms = model(ms, 1'b1, c, ld, lv, en, d, st, oc);
    e.tag = tag; e.w = mw; e.s = ms;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      compare_one({e.tag, ".wrap"}, e.w, w_count, w_carry, w_ovf, w_max, w_min);
      compare_one({e.tag, ".sat"},  e.s, s_count, s_carry, s_ovf, s_max, s_min);
    end
  endtask

  task automatic up(input string tag, input logic [SW-1:0] st);
    cyc(tag, 0, 0, '0, 1, DIR_UP, st, 0);
  endtask

  task automatic ld(input string tag, input logic [W-1:0] v);
    cyc(tag, 0, 1, v, 0, DIR_UP, '0, 0);
  endtask

  initial begin
    mw = '{count: '0, carry: 1'b0, ovf: 1'b0};
    ms = mw;
    repeat (2) @(posedge clk);
    #1;
    check("reset.w_count", 32'(w_count), 32'd0);
    check("reset.s_ovf", 32'(s_ovf), 32'd0);
    rst_n = 1'b1;

    // 1. Asynchronous reset mid-count
    for (int i = 0; i < 5; i++) up("pre_rst", 4'd1);
    check("pre_rst.count5", 32'(w_count), 32'd5);
    count_en = 1'b1;
    rst_n = 1'b0;
    #2;
    check("async_rst.w_count", 32'(w_count), 32'd0);
    check("async_rst.s_count", 32'(s_count), 32'd0);
    check("async_rst.w_carry", 32'(w_carry), 32'd0);
    check("async_rst.w_ovf", 32'(w_ovf), 32'd0);
    rst_n = 1'b1;
    mw = '{count: '0, carry: 1'b0, ovf: 1'b0};
    ms = mw;
    up("post_rst", 4'd1);

    // 2. Basic up, then step of zero
    cyc("clr", 1, 0, '0, 0, DIR_UP, '0, 0);
    for (int i = 0; i < 3; i++) up("basic_up", 4'd1);
    for (int i = 0; i < 2; i++) up("step0", 4'd0);

    // 3. Wrap up at the top
    ld("ld_3fe", 10'h3FE);
    up("to_max", 4'd1);
    up("wrap_up", 4'd1);
    cyc("idle_hold", 0, 0, '0, 0, DIR_UP, '0, 0);

    // 4. Wrap down below zero, at_min after loading zero
    cyc("clr2", 1, 0, '0, 0, DIR_UP, '0, 0);
    ld("ld_2", 10'd2);
    cyc("wrap_down", 0, 0, '0, 1, DIR_DOWN, 4'd3, 0);
    ld("ld_0", 10'd0);

    // 5. Saturation in both directions, repeated saturating step
    ld("ld_3fc", 10'h3FC);
    up("sat_up", 4'd5);
    up("sat_up_again", 4'd5);
    up("sat_max_step0", 4'd0);
    ld("ld_3", 10'd3);
    cyc("sat_down", 0, 0, '0, 1, DIR_DOWN, 4'd5, 0);
    cyc("sat_down_again", 0, 0, '0, 1, DIR_DOWN, 4'd1, 0);

    // 6. Priority and sticky-flag interactions
    cyc("clr_load", 1, 1, 10'h2AA, 1, DIR_UP, 4'd3, 0);
    cyc("load_en", 0, 1, 10'h155, 1, DIR_UP, 4'd7, 0);
    ld("ld_3ff", 10'h3FF);
    up("ovf_set", 4'd1);
    ld("ld_3ff_b", 10'h3FF);
    cyc("ovf_clr_vs_set", 0, 0, '0, 1, DIR_UP, 4'd1, 1);
    cyc("ovf_clr_alone", 0, 0, '0, 0, DIR_UP, '0, 1);
    up("ovf_set2", 4'd15);
    ld("ld_3f0", 10'h3F0);
    up("ovf_set3", 4'd15);
    up("ovf_set4", 4'd15);
    cyc("clr_vs_ovf", 1, 0, '0, 1, DIR_UP, 4'd15, 0);

    // Random mix of all controls
    for (int i = 0; i < 60; i++) begin
      cyc("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          W'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
          SW'($urandom), ($urandom_range(0, 7) == 0));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
